// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES shared constants, inverse S-box table and GF(2^8) helpers
// Used by aes_inv_round; gmul/xtime only matter when AES_INV_MIXCOL_EN is defined.
package aes_pkg;

  localparam int AES_W = 128;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant b only the set bits of b leave logic behind.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    p = 8'h00;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = xtime(s);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_inv_sbox8.sv
// rtl/aes_inv_sbox8.sv - 8-bit combinational inverse S-box lookup
module aes_inv_sbox8
  import aes_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] y
);

  assign y = INV_SBOX[x];

endmodule

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - registered AES-128 inverse round: InvShiftRows, InvSubBytes, AddRoundKey
// Optional InvMixColumns stage and mix_en port when AES_INV_MIXCOL_EN is defined.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [AES_W-1:0] state_in,
  input  logic [AES_W-1:0] round_key,
`ifdef AES_INV_MIXCOL_EN
  input  logic             mix_en,
`endif
  output logic             out_valid,
  output logic [AES_W-1:0] state_out
);

  logic [AES_W-1:0] sub;
  logic [AES_W-1:0] ark;
  logic [AES_W-1:0] result;

  // Byte k sits at row k%4, col k/4; InvShiftRows is folded into which input byte feeds each S-box.
  for (genvar k = 0; k < 16; k++) begin : g_byte
    localparam int R   = k % 4;
    localparam int C   = k / 4;
    localparam int SRC = R + 4 * ((C - R + 4) % 4);
    aes_inv_sbox8 u_sbox (
      .x(state_in[AES_W-1-8*SRC -: 8]),
      .y(sub[AES_W-1-8*k -: 8])
    );
  end

  assign ark = sub ^ round_key;

`ifdef AES_INV_MIXCOL_EN
  logic [AES_W-1:0] mixed;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = ark[AES_W-1-32*c  -: 8];
    assign a1 = ark[AES_W-9-32*c  -: 8];
    assign a2 = ark[AES_W-17-32*c -: 8];
    assign a3 = ark[AES_W-25-32*c -: 8];
    assign mixed[AES_W-1-32*c  -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
    assign mixed[AES_W-9-32*c  -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
    assign mixed[AES_W-17-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
    assign mixed[AES_W-25-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
  end

  assign result = mix_en ? mixed : ark;
`else
  assign result = ark;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      state_out <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) state_out <= result;
    end
  end

endmodule

// File: tb/tb_aes_inv_round.sv
// tb/tb_aes_inv_round.sv - self-checking bench for aes_inv_round (builds with or without AES_INV_MIXCOL_EN)
module tb_aes_inv_round;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic         mix_en;
  logic         out_valid;
  logic [127:0] state_out;

  int checks = 0;
  int errors = 0;

  aes_inv_round dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .state_in(state_in),
    .round_key(round_key),
`ifdef AES_INV_MIXCOL_EN
    .mix_en(mix_en),
`endif
    .out_valid(out_valid),
    .state_out(state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] st;
    logic [127:0] key;
    logic         mix;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Reference model: inverse S-box derived from GF(2^8) inversion plus the FIPS-197 affine map.
  logic [7:0] m_inv_sbox [256];
  logic [7:0] coef [4];

  function automatic logic [7:0] m_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= s;
      s = (s[7]) ? ((s << 1) ^ 8'h1b) : (s << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] m_fwd_sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (m_gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] key, input logic mix);
    logic [7:0] t [16];
    logic [127:0] o;
    for (int k = 0; k < 16; k++) begin
      int r = k % 4;
      int c = k / 4;
      int src = r + 4 * ((c - r + 4) % 4);
      t[k] = m_inv_sbox[st[127-8*src -: 8]] ^ key[127-8*k -: 8];
    end
    for (int k = 0; k < 16; k++) begin
      int r = k % 4;
      int c = k / 4;
      logic [7:0] acc = 8'h00;
      if (mix) begin
        for (int j = 0; j < 4; j++) acc ^= m_gmul(coef[(j - r + 4) % 4], t[j + 4*c]);
      end else begin
        acc = t[k];
      end
      o[127-8*k -: 8] = acc;
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [127:0] st, input logic [127:0] key, input logic mix);
    in_valid  = v;
    state_in  = st;
    round_key = key;
    mix_en    = mix;
  endtask

  logic [127:0] exp_q;
  logic         exp_v;
  logic         mix_r;
  logic [127:0] last;

  initial begin
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int x = 0; x < 256; x++) m_inv_sbox[m_fwd_sbox(8'(x))] = 8'(x);

    vecs.push_back('{128'h7ad5fda789ef4e272bca100b3d9ff59f, 128'h549932d1f08557681093ed9cbe2c974e, 1'b0,
                     128'he9f74eec023020f61bf2ccf2353c21c7});
    vecs.push_back('{128'h6353e08c0960e104cd70b751bacad0e7, 128'h000102030405060708090a0b0c0d0e0f, 1'b0,
                     128'h00112233445566778899aabbccddeeff});
    vecs.push_back('{128'h0, 128'h0, 1'b0, {16{8'h52}}});
    vecs.push_back('{128'h0, {16{8'hff}}, 1'b0, {16{8'had}}});
`ifdef AES_INV_MIXCOL_EN
    vecs.push_back('{128'h7ad5fda789ef4e272bca100b3d9ff59f, 128'h549932d1f08557681093ed9cbe2c974e, 1'b1,
                     128'h54d990a16ba09ab596bbf40ea111702f});
`endif

    // Reset wins over a simultaneous valid input
    rst = 1'b1;
    drive(1'b1, vecs[0].st, vecs[0].key, 1'b0);
    tick();
    check("reset_out_valid", {127'b0, out_valid}, 128'h0);
    check("reset_state_out", state_out, 128'h0);
    rst = 1'b0;
    drive(1'b0, 128'h0, 128'h0, 1'b0);
    tick();
    check("idle_out_valid", {127'b0, out_valid}, 128'h0);

    // Known-answer vectors, one at a time
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].st, vecs[i].key, vecs[i].mix);
      tick();
      check($sformatf("kat%0d_valid", i), {127'b0, out_valid}, 128'h1);
      check($sformatf("kat%0d_state", i), state_out, vecs[i].exp);
    end

    // Streaming: three back-to-back inputs then idle
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vecs[i].st, vecs[i].key, vecs[i].mix);
      tick();
      check($sformatf("stream%0d_valid", i), {127'b0, out_valid}, 128'h1);
      check($sformatf("stream%0d_state", i), state_out, vecs[i].exp);
    end
    drive(1'b0, 128'hdeadbeef_01234567_89abcdef_cafef00d, 128'h1, 1'b1);
    tick();
    check("stream_idle_valid", {127'b0, out_valid}, 128'h0);
    check("stream_idle_hold", state_out, vecs[2].exp);
    tick();
    check("stream_idle_hold2", state_out, vecs[2].exp);

    // Reset mid-stream discards in-flight data, then normal operation resumes
    drive(1'b1, vecs[1].st, vecs[1].key, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b1, vecs[0].st, vecs[0].key, 1'b0);
    tick();
    check("midrst_valid", {127'b0, out_valid}, 128'h0);
    check("midrst_state", state_out, 128'h0);
    rst = 1'b0;
    drive(1'b1, vecs[1].st, vecs[1].key, 1'b0);
    tick();
    check("post_rst_valid", {127'b0, out_valid}, 128'h1);
    check("post_rst_state", state_out, vecs[1].exp);

    // Randomized traffic against the reference model
    last = vecs[1].exp;
    for (int n = 0; n < 300; n++) begin
      logic v;
      logic [127:0] st, key;
      v   = ($urandom_range(0, 3) != 0);
      st  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
`ifdef AES_INV_MIXCOL_EN
      mix_r = 1'($urandom_range(0, 1));
`else
      mix_r = 1'b0;
`endif
      drive(v, st, key, mix_r);
      exp_v = v;
      if (v) last = ref_round(st, key, mix_r);
      exp_q = last;
      tick();
      check($sformatf("rand%0d_valid", n), {127'b0, out_valid}, {127'b0, exp_v});
      check($sformatf("rand%0d_state", n), state_out, exp_q);
    end

    drive(1'b0, 128'h0, 128'h0, 1'b0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
